mmio_access_ctrl: RTL and testbench

- Sequences every memory-mapped I/O access issued by the MEM stage of the pipelined CPU.
- Decoded MMIO loads and stores (window 0xFFFFFC00–0xFFFFFCFF) are turned into a req/ack transaction to one of NUM_DEV peripheral slots.
- The pipeline stays stalled until the slot acks or a timeout fires. Read data is then returned and the pipeline is released for exactly one cycle.
- Sits between the MEM-stage controls (io_read/io_write, ALU address, store data) and the peripheral bus.

---
 rtl/mmio_access_ctrl_if.sv | 38 +++
 rtl/mmio_access_ctrl.sv | 146 ++++++++++++++
 tb/tb_mmio_access_ctrl.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/mmio_access_ctrl_if.sv
// MEM-stage MMIO request/response and peripheral bus bundle.
// slave modport faces the access controller; master faces the CPU/bus side.
// NUM_DEV sizes the one-hot slot select and must match the controller.
interface mmio_access_ctrl_if #(
    parameter int NUM_DEV = 8
);
    // MEM-stage side
    logic               io_read;
    logic               io_write;
    logic [31:0]        addr;
    logic [31:0]        wdata;
    logic               stall;
    logic [31:0]        rdata;
    logic               rdata_valid;
    // Peripheral bus side
    logic               dev_req;
    logic               dev_we;
    logic [NUM_DEV-1:0] dev_sel;
    logic [7:0]         dev_addr;
    logic [31:0]        dev_wdata;
    logic               dev_ack;
    logic [31:0]        dev_rdata;
    // Error reporting
    logic               bus_err;
    logic               err_clr;

    modport slave (
        input  io_read, io_write, addr, wdata, dev_ack, dev_rdata, err_clr,
        output stall, rdata, rdata_valid, dev_req, dev_we, dev_sel,
               dev_addr, dev_wdata, bus_err
    );

    modport master (
        output io_read, io_write, addr, wdata, dev_ack, dev_rdata, err_clr,
        input  stall, rdata, rdata_valid, dev_req, dev_we, dev_sel,
               dev_addr, dev_wdata, bus_err
    );
endinterface

// File: rtl/mmio_access_ctrl.sv
// Sequences MEM-stage MMIO loads/stores into a req/ack peripheral transaction.
// Latency: stall 1 cycle in IDLE + 1..TIMEOUT cycles in ACCESS, then one release cycle.
// Backpressure: pipeline held via stall until ack or timeout; unmapped slots error at once.
module mmio_access_ctrl #(
    parameter int          NUM_DEV  = 8,
    parameter int          TIMEOUT  = 16,
    parameter logic [31:0] ERR_DATA = 32'hDEADBEEF
) (
    input  logic               clk,
    input  logic               rst_n,
    mmio_access_ctrl_if.slave  bus
);
    localparam int             CW        = $clog2(TIMEOUT);
    localparam logic [CW-1:0]  CNT_LAST  = CW'(TIMEOUT - 1);
    localparam logic [3:0]     NUM_DEV_W = 4'(NUM_DEV);

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [NUM_DEV-1:0] sel_q, sel_d;
    logic [7:0]         addr_q, addr_d;
    logic [31:0]        wdata_q, wdata_d;
    logic               we_q, we_d;
    logic [31:0]        rdata_q, rdata_d;
    logic               bus_err_q, bus_err_d;

    logic               err_set;
    logic               stall;
    logic               rdata_valid;
    logic               dev_req;
    logic [2:0]         slot;
    logic [NUM_DEV-1:0] sel_onehot;

    // Decode the requested slot into a one-hot select
    always_comb begin
        slot       = bus.addr[6:4];
        sel_onehot = '0;
        for (int i = 0; i < NUM_DEV; i++) begin
            sel_onehot[i] = (slot == 3'(i));
        end
    end

    // Next-state, latched transaction fields and pipeline/bus controls
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        sel_d       = sel_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        we_d        = we_q;
        rdata_d     = rdata_q;
        err_set     = 1'b0;
        stall       = 1'b0;
        rdata_valid = 1'b0;
        dev_req     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.io_read || bus.io_write) begin
                    // Stall in the same cycle so the MEM-stage instruction is held
                    stall   = 1'b1;
                    addr_d  = bus.addr[7:0];
                    wdata_d = bus.wdata;
                    we_d    = bus.io_write;  // read+write together counts as a write
                    cnt_d   = '0;
                    if ({1'b0, slot} < NUM_DEV_W) begin
                        sel_d   = sel_onehot;
                        state_d = S_ACCESS;
                    end else begin
                        rdata_d = ERR_DATA;
                        err_set = 1'b1;
                        state_d = S_DONE;
                    end
                end
            end
            S_ACCESS: begin
                stall   = 1'b1;
                dev_req = 1'b1;
                cnt_d   = cnt_q + 1'b1;
                // Ack is checked first so a last-cycle ack never raises an error
                if (bus.dev_ack) begin
                    if (!we_q) begin
                        rdata_d = bus.dev_rdata;
                    end
                    sel_d   = '0;
                    state_d = S_DONE;
                end else if (cnt_q == CNT_LAST) begin
                    if (!we_q) begin
                        rdata_d = ERR_DATA;
                    end
                    err_set = 1'b1;
                    sel_d   = '0;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                // Release cycle; any MMIO request still asserted belongs to the
                // completing instruction and is deliberately not looked at here
                rdata_valid = 1'b1;
                state_d     = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        bus_err_d = err_set | (bus_err_q & ~bus.err_clr);
    end

    // State and datapath registers; reset abandons any in-flight transaction
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            sel_q     <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            we_q      <= 1'b0;
            rdata_q   <= '0;
            bus_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            sel_q     <= sel_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            we_q      <= we_d;
            rdata_q   <= rdata_d;
            bus_err_q <= bus_err_d;
        end
    end

    // Drive the bundle
    always_comb begin
        bus.stall       = stall;
        bus.rdata       = rdata_q;
        bus.rdata_valid = rdata_valid;
        bus.dev_req     = dev_req;
        bus.dev_we      = we_q;
        bus.dev_sel     = sel_q;
        bus.dev_addr    = addr_q;
        bus.dev_wdata   = wdata_q;
        bus.bus_err     = bus_err_q;
    end
endmodule

// File: tb/tb_mmio_access_ctrl.sv
// Bench for mmio_access_ctrl: directed plan steps plus random transactions.
// Expected results come from a transaction-level model (stall/req counts, rdata, error).
// A second instance with NUM_DEV=4 covers the unmapped-slot path.
module tb_mmio_access_ctrl;
    localparam int          TIMEOUT  = 16;
    localparam logic [31:0] ERR_DATA = 32'hDEADBEEF;

    logic clk;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;

    logic [31:0] m_rdata;   // model: rdata currently presented
    logic        m_err;     // model: sticky error flag

    mmio_access_ctrl_if #(.NUM_DEV(8)) m ();
    mmio_access_ctrl_if #(.NUM_DEV(4)) m4 ();

    mmio_access_ctrl #(.NUM_DEV(8), .TIMEOUT(TIMEOUT), .ERR_DATA(ERR_DATA)) dut (
        .clk(clk), .rst_n(rst_n), .bus(m)
    );
    mmio_access_ctrl #(.NUM_DEV(4), .TIMEOUT(TIMEOUT), .ERR_DATA(ERR_DATA)) dut4 (
        .clk(clk), .rst_n(rst_n), .bus(m4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%08h expected=%08h", tag, got, exp);
        end
    endtask

    // One MMIO instruction held until release. ack_at = index of the ACCESS cycle
    // that carries dev_ack; ack_at >= TIMEOUT means the peripheral never answers.
    task automatic run_txn(input bit w, input bit both, input logic [31:0] a,
                           input logic [31:0] wd, input int ack_at,
                           input logic [31:0] ackd, input bit spurious);
        int         req_seen  = 0;
        int         stall_seen = 0;
        bit         done      = 0;
        int         exp_req;
        int         exp_stall;
        logic [7:0] exp_sel;
        exp_sel = 8'd1 << a[6:4];
        if (ack_at < TIMEOUT) begin
            exp_req   = ack_at + 1;
            exp_stall = ack_at + 2;
            if (!w) m_rdata = ackd;
        end else begin
            exp_req   = TIMEOUT;
            exp_stall = TIMEOUT + 1;
            if (!w) m_rdata = ERR_DATA;
            m_err = 1'b1;
        end
        for (int cyc = 0; cyc < TIMEOUT + 10 && !done; cyc++) begin
            @(negedge clk);
            m.io_write  = w;
            m.io_read   = !w || both;
            m.addr      = a;
            m.wdata     = wd;
            m.err_clr   = 1'b0;
            m.dev_ack   = 1'b0;
            m.dev_rdata = $urandom;
            #1;
            if (m.rdata_valid) begin
                done = 1;
                check("done_stall", 32'(m.stall), 32'd0);
                check("done_req", 32'(m.dev_req), 32'd0);
                check("done_sel", 32'(m.dev_sel), 32'd0);
                check("rdata", m.rdata, m_rdata);
                check("bus_err", 32'(m.bus_err), 32'(m_err));
                if (spurious) m.dev_ack = 1'b1;
            end else begin
                if (m.stall) stall_seen++;
                if (m.dev_req) begin
                    check("dev_sel", 32'(m.dev_sel), 32'(exp_sel));
                    check("dev_addr", 32'(m.dev_addr), 32'(a[7:0]));
                    check("dev_we", 32'(m.dev_we), 32'(w));
                    if (w) check("dev_wdata", m.dev_wdata, wd);
                    if (req_seen == ack_at) begin
                        m.dev_ack   = 1'b1;
                        m.dev_rdata = ackd;
                    end
                    req_seen++;
                end else if (spurious) begin
                    m.dev_ack = 1'($urandom_range(0, 1));
                end
            end
        end
        check("release_seen", 32'(done), 32'd1);
        check("stall_cycles", stall_seen, exp_stall);
        check("req_cycles", req_seen, exp_req);
    endtask

    // Cycles with no MMIO instruction; err_clr pulsed in cycle clr_at (-1: never).
    task automatic idle(input int n, input int clr_at);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            m.io_read   = 1'b0;
            m.io_write  = 1'b0;
            m.dev_ack   = 1'($urandom_range(0, 1));
            m.dev_rdata = $urandom;
            m.err_clr   = (i == clr_at);
            #1;
            check("idle_stall", 32'(m.stall), 32'd0);
            check("idle_req", 32'(m.dev_req), 32'd0);
            check("idle_valid", 32'(m.rdata_valid), 32'd0);
            check("idle_rdata", m.rdata, m_rdata);
            check("idle_err", 32'(m.bus_err), 32'(m_err));
            if (i == clr_at) m_err = 1'b0;
        end
    endtask

    initial begin
        rst_n = 1'b0;
        m.io_read = 0; m.io_write = 0; m.addr = 0; m.wdata = 0;
        m.dev_ack = 0; m.dev_rdata = 0; m.err_clr = 0;
        m4.io_read = 0; m4.io_write = 0; m4.addr = 0; m4.wdata = 0;
        m4.dev_ack = 0; m4.dev_rdata = 0; m4.err_clr = 0;
        m_rdata = '0;
        m_err   = 1'b0;

        // Reset values
        #12;
        check("rst_stall", 32'(m.stall), 32'd0);
        check("rst_valid", 32'(m.rdata_valid), 32'd0);
        check("rst_req", 32'(m.dev_req), 32'd0);
        check("rst_we", 32'(m.dev_we), 32'd0);
        check("rst_err", 32'(m.bus_err), 32'd0);
        check("rst_sel", 32'(m.dev_sel), 32'd0);
        check("rst_addr", 32'(m.dev_addr), 32'd0);
        check("rst_wdata", m.dev_wdata, 32'd0);
        check("rst_rdata", m.rdata, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(2, -1);

        // Read slot 2, ack in third ACCESS cycle: 4 stall cycles
        run_txn(0, 0, 32'hFFFFFC20, 32'h0, 2, 32'h000000A5, 0);
        idle(1, -1);
        // Write slot 1, ack in first ACCESS cycle: 2 stall cycles
        run_txn(1, 0, 32'hFFFFFC10, 32'h12345678, 0, 32'hCAFEF00D, 0);
        idle(1, -1);
        // Read with no ack: timeout, sticky error, then clear
        run_txn(0, 0, 32'hFFFFFC30, 32'h0, TIMEOUT + 5, 32'h0, 0);
        idle(3, -1);
        idle(3, 0);
        // Back-to-back write then read with spurious acks
        run_txn(1, 1, 32'hFFFFFC70, 32'hA5A55A5A, 1, 32'h11111111, 1);
        run_txn(0, 0, 32'hFFFFFC64, 32'h0, 3, 32'h76543210, 1);
        idle(2, -1);
        // Ack on the last allowed cycle wins over timeout
        run_txn(0, 0, 32'hFFFFFC08, 32'h0, TIMEOUT - 1, 32'h0BADF00D, 0);
        idle(1, -1);

        // Random transactions
        for (int t = 0; t < 40; t++) begin
            bit          w;
            logic [7:0]  lo;
            w  = 1'($urandom_range(0, 1));
            lo = 8'($urandom);
            run_txn(w, w && ($urandom_range(0, 1) == 1), {24'hFFFFFC, lo}, $urandom,
                    $urandom_range(0, TIMEOUT + 2), $urandom, 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 2) == 0)
                idle($urandom_range(1, 3), ($urandom_range(0, 1) == 1) ? 0 : -1);
        end

        // Reset mid-ACCESS after making bus_err set
        run_txn(0, 0, 32'hFFFFFC40, 32'h0, TIMEOUT + 1, 32'h0, 0);
        @(negedge clk);
        m.io_read = 1'b1; m.io_write = 1'b0; m.addr = 32'hFFFFFC40; m.dev_ack = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("pre_rst_req", 32'(m.dev_req), 32'd1);
        rst_n = 1'b0;
        m.io_read = 1'b0;
        #1;
        check("mid_rst_req", 32'(m.dev_req), 32'd0);
        check("mid_rst_stall", 32'(m.stall), 32'd0);
        check("mid_rst_err", 32'(m.bus_err), 32'd0);
        check("mid_rst_sel", 32'(m.dev_sel), 32'd0);
        m_rdata = '0;
        m_err   = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        idle(2, -1);
        run_txn(0, 0, 32'hFFFFFC50, 32'h0, 1, 32'h00C0FFEE, 0);

        // NUM_DEV=4: slot 5 is unmapped
        @(negedge clk);
        m.io_read = 1'b0;
        m4.io_read = 1'b1; m4.addr = 32'hFFFFFC50;
        #1;
        check("u4_stall", 32'(m4.stall), 32'd1);
        check("u4_req", 32'(m4.dev_req), 32'd0);
        @(negedge clk);
        #1;
        check("u4_done_stall", 32'(m4.stall), 32'd0);
        check("u4_req2", 32'(m4.dev_req), 32'd0);
        check("u4_valid", 32'(m4.rdata_valid), 32'd1);
        check("u4_rdata", m4.rdata, ERR_DATA);
        check("u4_err", 32'(m4.bus_err), 32'd1);
        // Valid slot 3 on the small instance
        @(negedge clk);
        m4.addr = 32'hFFFFFC30;
        #1;
        check("u4_v_stall", 32'(m4.stall), 32'd1);
        @(negedge clk);
        #1;
        check("u4_v_req", 32'(m4.dev_req), 32'd1);
        check("u4_v_sel", 32'(m4.dev_sel), 32'h8);
        m4.dev_ack = 1'b1; m4.dev_rdata = 32'h00003333;
        @(negedge clk);
        m4.dev_ack = 1'b0; m4.io_read = 1'b0;
        #1;
        check("u4_v_valid", 32'(m4.rdata_valid), 32'd1);
        check("u4_v_rdata", m4.rdata, 32'h00003333);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
